seg7_to_bcd_capture: RTL
========================

Name: seg7_to_bcd_capture

Overview:
- Receiving end of a multiplexed seven-segment display interface: samples segment lines plus one-hot digit-select lines and recovers the BCD digit behind each pattern.
- Qualifies each pattern by a stability window, stores one BCD value per digit position, and flags patterns outside the 0-9 set.
- Used to check display drivers in-system and as a scoreboard front end in display testbenches.

Parameters:
- N_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines; bit6=a, bit5=b, ... bit0=g; 1 = lit.
- an_in  input  N_DIGITS  digit select; one-hot, 1 = digit active; bit i = digit i.
- bcd_out  output  4*N_DIGITS  captured BCD; nibble i = digit i; blank stored as 4'hF.
- digit_valid  output  N_DIGITS  bit i set once digit i holds a legal capture.
- cap_strobe  output  1  one-cycle pulse on every capture attempt, legal or illegal.
- cap_idx  output  max(1,$clog2(N_DIGITS))  digit index of the current capture attempt.
- err_illegal  output  1  one-cycle pulse, same cycle as cap_strobe, when the pattern is illegal.
- frame_done  output  1  one-cycle pulse when every digit has been legally captured since the last frame_done.

Behaviour:
- Reset (synchronous): bcd_out all 4'hF, digit_valid=0, cap_strobe=0, cap_idx=0, err_illegal=0, frame_done=0, capture mask=0, FSM=IDLE, stability counter=0.
- Legal pattern table (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000 maps to 4'hF and counts as legal.
  - Any other pattern is illegal.
- Input pair (seg_in, an_in) is registered every edge; the counter compares the current input against the last registered pair.
- FSM:
  - IDLE: an_in not one-hot (zero or multiple bits set). Counter held at 0. Leave IDLE when an_in is one-hot; go to TRACK with counter=1.
  - TRACK: pair equal to the previous sample -> counter+1; pair differs -> counter=1. When the counter reaches STABLE_CYCLES, capture on that edge and go to HOLD.
  - HOLD: no further capture while the pair stays unchanged. On any change go to TRACK with counter=1, or to IDLE if an_in is not one-hot.
  - Non-one-hot an_in in any state -> IDLE.
- Capture timing: the pair must be sampled unchanged on STABLE_CYCLES consecutive edges. All outputs update directly after the last of those edges. STABLE_CYCLES=1 captures on the first edge a new one-hot pair is seen.
- Legal capture:
  - write nibble cap_idx of bcd_out
  - set digit_valid[cap_idx] and capture-mask bit cap_idx
  - pulse cap_strobe.
- Illegal capture:
  - bcd_out unchanged
  - clear digit_valid[cap_idx] and mask bit cap_idx
  - pulse cap_strobe and err_illegal.
- frame_done: pulses in the same cycle as the legal capture that completes the mask to all ones; the mask clears on that edge. digit_valid is not cleared by frame_done.
- Recapture of an already-valid digit overwrites its nibble and leaves its valid bit set.
- Reset asserted mid-TRACK abandons the pending capture; no strobe is produced.

Optional Feature:
- Macro SEG7_ACTIVE_LOW_EN.
- Defined: seg_in and an_in are inverted before any processing (common-anode, active-low display lines). All later rules apply to the inverted values.
- Undefined: inputs are active-high as listed under Ports.

Test Plan:
- Reset, then hold an_in=4'b0001 and seg_in=7'b0110000 for 4 edges -> after the 4th edge: cap_strobe=1, cap_idx=0, bcd_out[3:0]=1, digit_valid=4'b0001. No further strobe while inputs are held.
- Scan digits 0..3 with 2,0,2,5 for 4 cycles each -> four strobes; frame_done pulses with the digit-3 capture; bcd_out=16'h5202.
- Hold seg_in=7'b1111110 on digit 1 for only 3 cycles, then change -> no cap_strobe; digit_valid unchanged.
- an_in=4'b0100 with seg_in=7'b1000000 held 4 cycles -> cap_strobe=1, err_illegal=1, cap_idx=2; digit_valid[2]=0; bcd_out nibble 2 unchanged.
- an_in=4'b0011 or 4'b0000 held 10 cycles -> no strobe. Assert rst in the 3rd cycle of a valid hold -> all outputs at reset values, no capture.
- With SEG7_ACTIVE_LOW_EN defined: an_in=4'b1110 and seg_in=7'b0000100 (inverted 9) held 4 cycles -> bcd_out[3:0]=9, digit_valid[0]=1.

Source files
------------

// File: rtl/seg7_to_bcd_capture.sv
// Recovers the BCD digit behind each multiplexed seven-segment pattern after a stability window.
// Define SEG7_ACTIVE_LOW_EN for common-anode (active-low) seg_in/an_in lines.
module seg7_to_bcd_capture #(
  parameter int  N_DIGITS      = 4,
  parameter int  STABLE_CYCLES = 4,
  localparam int IdxW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CntW          = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  cap_strobe,
  output logic [IdxW-1:0]       cap_idx,
  output logic                  err_illegal,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

  logic [6:0]            segW;
  logic [N_DIGITS-1:0]   anW;

`ifdef SEG7_ACTIVE_LOW_EN
  assign segW = ~seg_in;
  assign anW  = ~an_in;
`else
  assign segW = seg_in;
  assign anW  = an_in;
`endif

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [6:0]            lastSeg_q;
  logic [N_DIGITS-1:0]   lastAn_q;
  logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  strobe_q, strobe_d;
  logic                  err_q, err_d;
  logic                  frame_q, frame_d;
  logic [IdxW-1:0]       idx_q, idx_d;

  logic                  anOneHot;
  logic                  samePair;
  logic                  capture;
  logic [IdxW-1:0]       activeIdx;
  logic                  patternLegal;
  logic [3:0]            patternVal;

  assign anOneHot = (anW != '0) && ((anW & (anW - N_DIGITS'(1))) == '0);
  assign samePair = (segW == lastSeg_q) && (anW == lastAn_q);

  always_comb begin
    activeIdx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (anW[i]) activeIdx = IdxW'(i);
    end
  end

  // Blank decodes to 4'hF and is treated as a legal digit.
  always_comb begin
    patternLegal = 1'b1;
    patternVal   = 4'hF;
    case (segW)
      7'b1111110: patternVal = 4'd0;
      7'b0110000: patternVal = 4'd1;
      7'b1101101: patternVal = 4'd2;
      7'b1111001: patternVal = 4'd3;
      7'b0110011: patternVal = 4'd4;
      7'b1011011: patternVal = 4'd5;
      7'b1011111: patternVal = 4'd6;
      7'b1110000: patternVal = 4'd7;
      7'b1111111: patternVal = 4'd8;
      7'b1111011: patternVal = 4'd9;
      7'b0000000: patternVal = 4'hF;
      default:    patternLegal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    if (!anOneHot) begin
      state_d = IDLE;
      count_d = '0;
    end else if (!(state_q == HOLD && samePair)) begin
      count_d = (state_q == TRACK && samePair) ? count_q + CntW'(1) : CntW'(1);
      if (count_d >= CntW'(STABLE_CYCLES)) begin
        capture = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = TRACK;
      end
    end
  end

  // anW is one-hot whenever capture is set, so it doubles as the write mask.
  always_comb begin
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    frame_d  = 1'b0;
    idx_d    = idx_q;
    if (capture) begin
      strobe_d = 1'b1;
      idx_d    = activeIdx;
      if (patternLegal) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (anW[i]) bcd_d[4*i +: 4] = patternVal;
        end
        valid_d = valid_q | anW;
        mask_d  = mask_q | anW;
        if (mask_d == '1) begin
          frame_d = 1'b1;
          mask_d  = '0;
        end
      end else begin
        err_d   = 1'b1;
        valid_d = valid_q & ~anW;
        mask_d  = mask_q & ~anW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      lastSeg_q <= '0;
      lastAn_q  <= '0;
      bcd_q     <= '1;
      valid_q   <= '0;
      mask_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lastSeg_q <= segW;
      lastAn_q  <= anW;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      mask_q    <= mask_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign cap_strobe  = strobe_q;
  assign cap_idx     = idx_q;
  assign err_illegal = err_q;
  assign frame_done  = frame_q;

endmodule
